// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and constants for the multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int unsigned MAX_WIDTH = 64;
  // Quotient reported for any divide by zero; sliced down to the unit width.
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOT = '1;

  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One-bit restoring division step: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             quot_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted  = {rem, dividend_bit};
    quot_bit = (shifted >= {1'b0, divisor});
    // rem < divisor on entry, so a successful subtraction always fits in WIDTH bits.
    diff     = shifted[WIDTH-1:0] - divisor;
    rem_next = quot_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies (MULDIV_ASSERT_ON adds a busy check).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned      CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] QUOT_DIV0 = DIV0_QUOT[WIDTH-1:0];

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mag_a_q, mag_b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               is_div_q, neg_res_q, neg_a_q, b_zero_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Launch decode
  logic             launch_arith, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    launch_arith = is_arith_op(op);
    a_neg        = is_signed_op(op) & a[WIDTH-1];
    b_neg        = is_signed_op(op) & b[WIDTH-1];
    a_mag        = a_neg ? (~a + 1'b1) : a;
    b_mag        = b_neg ? (~b + 1'b1) : b;
  end

  // Division datapath: remainder lives in the upper half of the accumulator.
  logic [WIDTH-1:0] step_rem;
  logic             step_quot;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem          (acc_q[2*WIDTH-1:WIDTH]),
    .divisor      (mag_b_q),
    .dividend_bit (mag_a_q[WIDTH-1]),
    .rem_next     (step_rem),
    .quot_bit     (step_quot)
  );

  // Multiply datapath: add multiplicand on the current multiplier LSB, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_next;

  always_comb begin
    mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mag_b_q[0] ? {1'b0, mag_a_q} : '0);
    mul_acc_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Sign fix applied in FIX
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quot_mag, rem_mag, quot_fix, rem_fix;

  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod_mag = {{WIDTH{1'b0}}, mag_a_q} * {{WIDTH{1'b0}}, mag_b_q};
`else
    prod_mag = acc_q;
`endif
    prod_fix = neg_res_q ? (~prod_mag + 1'b1) : prod_mag;
    quot_mag = acc_q[WIDTH-1:0];
    rem_mag  = acc_q[2*WIDTH-1:WIDTH];
    quot_fix = neg_res_q ? (~quot_mag + 1'b1) : quot_mag;
    rem_fix  = neg_a_q ? (~rem_mag + 1'b1) : rem_mag;
    if (b_zero_q) begin
      quot_fix = QUOT_DIV0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      b_zero_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !flush) begin
            if (launch_arith) begin
              mag_a_q   <= a_mag;
              mag_b_q   <= b_mag;
              is_div_q  <= op[1];
              neg_res_q <= a_neg ^ b_neg;
              neg_a_q   <= a_neg;
              b_zero_q  <= op[1] && (b == '0);
              acc_q     <= '0;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
              state_q   <= op[1] ? ST_CALC : ST_FIX;
`else
              state_q   <= ST_CALC;
`endif
            end else if (op == OP_MTHI) begin
              hi_q   <= a;
              done_q <= 1'b1;
            end else if (op == OP_MTLO) begin
              lo_q   <= a;
              done_q <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (is_div_q) begin
              acc_q   <= {step_rem, acc_q[WIDTH-2:0], step_quot};
              mag_a_q <= {mag_a_q[WIDTH-2:0], 1'b0};
            end else begin
              acc_q   <= mul_acc_next;
              mag_b_q <= {1'b0, mag_b_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          if (!flush) begin
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
            done_q <= 1'b1;
          end
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

`ifdef MULDIV_ASSERT_ON
  // A start while busy is dropped; the issuing pipeline should have stalled.
  start_while_busy: assert property (@(posedge clk) disable iff (!rst) !(busy_q && start));
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: table of ops plus flush/reset/ignore sequences.
module tb_muldiv_unit;

  logic        clk, rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int passed = 0;

  muldiv_unit #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic int exp_lat(input logic [2:0] o);
    if (o == 3'b100 || o == 3'b101) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (o == 3'b000 || o == 3'b001) return 2;
`endif
    return 34;
  endfunction

  // Launch one op and wait (bounded) for done; lat counts edges from launch, -1 on timeout.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcyc);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bcyc = 0;
    while (!done && lat < 80) begin
      if (busy) bcyc++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  initial begin
    int lat, bc, ndone, nbusy;

    vecs[0]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'b011, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{3'b010, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{3'b001, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[10] = '{3'b100, 32'h00001234, 32'h0,        32'h00001234, 32'h23456780};
    vecs[11] = '{3'b101, 32'h00005678, 32'h0,        32'h00001234, 32'h00005678};

    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
      check($sformatf("v%0d hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d latency", i), lat, exp_lat(vecs[i].op));
      check($sformatf("v%0d busy cycles", i), bc,
            (vecs[i].op[2]) ? 0 : exp_lat(vecs[i].op) - 1);
    end

    // Undefined op: no done, no busy, HI/LO untouched
    @(negedge clk);
    op = 3'b110; a = 32'hAAAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; nbusy = 0;
    repeat (40) begin
      if (done) ndone++;
      if (busy) nbusy++;
      @(negedge clk);
    end
    check("undef done", ndone, 0);
    check("undef busy", nbusy, 0);
    check("undef hi", hi, 32'h1234);
    check("undef lo", lo, 32'h5678);

    // Flush DIVU 100/7 at iteration 10
    @(negedge clk);
    op = 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("flush busy before", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy after", busy, 0);
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("flush no done", ndone, 0);
    check("flush hi kept", hi, 32'h1234);
    check("flush lo kept", lo, 32'h5678);
    run_op(3'b011, 32'd100, 32'd7, lat, bc);
    check("relaunch hi", hi, 2);
    check("relaunch lo", lo, 14);
    check("relaunch latency", lat, 34);

    // Start while busy is ignored: DIVU 1000/7 with a stray MTLO mid-flight
    @(negedge clk);
    op = 3'b011; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (4) begin
      @(negedge clk);
      lat++;
    end
    op = 3'b101; a = 32'hBEEF; start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    check("busy-start latency", lat, 34);
    check("busy-start hi", hi, 6);
    check("busy-start lo", lo, 142);
    repeat (3) @(negedge clk);
    check("busy-start lo stable", lo, 142);

    // flush && start in IDLE: op not launched
    @(negedge clk);
    op = 3'b100; a = 32'h9999; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle flush done", done, 0);
    check("idle flush busy", busy, 0);
    check("idle flush hi", hi, 6);

    // Async reset mid-division, then a clean op
    @(negedge clk);
    op = 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    check("async rst hi", hi, 0);
    check("async rst lo", lo, 0);
    @(negedge clk);
    rst = 1'b1;
    run_op(3'b001, 32'd6, 32'd7, lat, bc);
    check("post-reset hi", hi, 0);
    check("post-reset lo", lo, 42);
    check("post-reset latency", lat, exp_lat(3'b001));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
